dot_seq: RTL and testbench
==========================

DOT_SEQ -- requirements
Module: dot_seq

Interface
REQ-001 SHALL have parameter IW, default 8: signed element width of vector and matrix memories.
REQ-002 SHALL have parameter LW, default 6: width of rows/cols counts and vector address.
REQ-003 SHALL have parameter AW, default 10: matrix memory address width.
REQ-004 SHALL have port clk  input  1  clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  job request; sampled in IDLE only.
REQ-007 SHALL have port rows  input  LW  matrix row count, captured at start.
REQ-008 SHALL have port cols  input  LW  vector length (columns per row), captured at start.
REQ-009 SHALL have port busy  output  1  high in any state other than IDLE.
REQ-010 SHALL have port done  output  1  one-cycle pulse at job end.
REQ-011 SHALL have port mem_ren  output  1  read enable shared by both memories.
REQ-012 SHALL have port vec_addr  output  LW  vector memory address (column index).
REQ-013 SHALL have port mat_addr  output  AW  matrix memory address, row-major.
REQ-014 SHALL have ports vec_rdata and mat_rdata  input  IW each  signed read data, valid the cycle after mem_ren; memories hold rdata while mem_ren low.
REQ-015 SHALL have port data  output  2*IW  signed product beat to accumulator.
REQ-016 SHALL have ports ovalid, first, last  output  1 each  beat valid, first column of row, last column of row.
REQ-017 SHALL have port ordy  input  1  downstream ready; beat transfers when ovalid and ordy.

Function
REQ-018 SHALL implement FSM IDLE, RUN, DRAIN; reset state IDLE.
REQ-019 IDLE: start=1 with rows>=1 and cols>=1 SHALL capture rows/cols, clear row/col counters and mat_addr base, go RUN next cycle.
REQ-020 IDLE: start=1 with rows=0 or cols=0 SHALL stay IDLE, emit no beats, pulse done next cycle.
REQ-021 start while busy SHALL be ignored.
REQ-022 RUN: each non-stalled cycle SHALL assert mem_ren with vec_addr=col, mat_addr=row*cols+col (running counter, no multiplier), then advance col; col wraps to 0 and row increments after col=cols-1.
REQ-023 After issuing (rows-1, cols-1) SHALL go DRAIN; DRAIN SHALL go IDLE once no beat remains in pipeline, with done=1 that transition cycle.
REQ-024 Stage 2 SHALL register signed vec_rdata*mat_rdata (full 2*IW, exact) plus first/last tags into output register.
REQ-025 Latency: start in cycle T, ordy=1 throughout -> first mem_ren cycle T+1, first ovalid cycle T+3, one beat per cycle, rows*cols beats total.
REQ-026 Stall = ovalid and not ordy; during stall mem_ren=0, addresses, counters, tags, data SHALL hold stable; no beat dropped or duplicated.
REQ-027 first=1 iff beat column 0; last=1 iff column cols-1; cols=1 -> both set on every beat.
REQ-028 first/last/data SHALL be 0 when ovalid=0.
REQ-029 mat_addr SHALL wrap modulo 2^AW; rows*cols > 2^AW is unsupported.

Reset
REQ-030 rst SHALL force IDLE, counters 0, busy, done, mem_ren, ovalid, first, last, data, vec_addr, mat_addr all 0, from any state including mid-job; no done pulse for aborted job.
REQ-031 rst SHALL override start in the same cycle.

Configuration
REQ-032 Macro DOT_SEQ_ROWIDX_EN defined: extra output row_idx  LW  row index of current beat, held with beat, 0 when ovalid=0 and in reset.
REQ-033 Macro DOT_SEQ_ROWIDX_EN undefined: row_idx port absent; all other behaviour identical.

Verification
REQ-034 rows=2, cols=3, vec={1,2,3}, mat={1,1,1,-1,2,4}, ordy=1 -> beats 1,2,3 then -1,4,12; first on beats 1,4; last on 3,6; done at T+8.
REQ-035 rows=3, cols=1, vec={-128}, mat={-128,127,0} -> beats 16384, -16256, 0, each with first=last=1.
REQ-036 Same as REQ-034 with ordy=0 cycles T+4..T+6 -> beat 2 held stable 3 cycles, identical 6-beat sequence, done delayed 3 cycles.
REQ-037 start with rows=0, cols=5 -> no mem_ren, no ovalid, done pulse at T+1.
REQ-038 rst at T+4 of REQ-034 job -> next cycle all outputs 0, IDLE, no done; new start then runs full job correctly.
REQ-039 start re-asserted at T+2 of running job -> ignored; beat count still rows*cols.

Source files
------------

// File: rtl/dot_seq.sv
// Matrix-vector product beat sequencer: streams vec[col]*mat[row][col] beats row by row.
// Optional row index output enabled by defining DOT_SEQ_ROWIDX_EN.
module dot_seq #(
  parameter int IW = 8,
  parameter int LW = 6,
  parameter int AW = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LW-1:0]          rows,
  input  logic [LW-1:0]          cols,
  output logic                   busy,
  output logic                   done,
  output logic                   mem_ren,
  output logic [LW-1:0]          vec_addr,
  output logic [AW-1:0]          mat_addr,
  input  logic signed [IW-1:0]   vec_rdata,
  input  logic signed [IW-1:0]   mat_rdata,
  output logic signed [2*IW-1:0] data,
  output logic                   ovalid,
  output logic                   first,
  output logic                   last,
  input  logic                   ordy
`ifdef DOT_SEQ_ROWIDX_EN
  ,
  output logic [LW-1:0]          row_idx
`endif
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  state_t                 state, state_n;
  logic [LW-1:0]          rows_r, cols_r, col, row;
  logic                   p1_valid, p1_first, p1_last;
  logic                   zero_done, stall, col_end, row_end, accept, go_zero;
  logic signed [2*IW-1:0] prod;
`ifdef DOT_SEQ_ROWIDX_EN
  logic [LW-1:0]          p1_row;
`endif

  assign prod     = vec_rdata * mat_rdata;
  assign vec_addr = col;
  assign busy     = (state != IDLE);

  always_comb begin
    state_n = state;
    mem_ren = 1'b0;
    done    = zero_done;
    accept  = 1'b0;
    go_zero = 1'b0;
    stall   = ovalid & ~ordy;
    col_end = (col == cols_r - LW'(1));
    row_end = (row == rows_r - LW'(1));
    case (state)
      IDLE: begin
        if (start) begin
          if (rows != '0 && cols != '0) begin
            accept  = 1'b1;
            state_n = RUN;
          end else begin
            go_zero = 1'b1;
          end
        end
      end
      RUN: begin
        if (!stall) begin
          mem_ren = 1'b1;
          if (col_end && row_end) state_n = DRAIN;
        end
      end
      DRAIN: begin
        // Pipeline is empty once stage 1 is idle and the output beat (if any) leaves now.
        if (!p1_valid && !stall) begin
          state_n = IDLE;
          done    = 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rows_r    <= '0;
      cols_r    <= '0;
      col       <= '0;
      row       <= '0;
      mat_addr  <= '0;
      zero_done <= 1'b0;
      p1_valid  <= 1'b0;
      p1_first  <= 1'b0;
      p1_last   <= 1'b0;
      ovalid    <= 1'b0;
      first     <= 1'b0;
      last      <= 1'b0;
      data      <= '0;
`ifdef DOT_SEQ_ROWIDX_EN
      p1_row    <= '0;
      row_idx   <= '0;
`endif
    end else begin
      zero_done <= go_zero;
      if (accept) begin
        rows_r   <= rows;
        cols_r   <= cols;
        col      <= '0;
        row      <= '0;
        mat_addr <= '0;
      end else if (mem_ren) begin
        // Row-major order makes row*cols+col a plain incrementing address.
        mat_addr <= mat_addr + AW'(1);
        if (col_end) begin
          col <= '0;
          row <= row + LW'(1);
        end else begin
          col <= col + LW'(1);
        end
      end
      if (!stall) begin
        p1_valid <= mem_ren;
        p1_first <= mem_ren & (col == '0);
        p1_last  <= mem_ren & col_end;
        ovalid   <= p1_valid;
        data     <= p1_valid ? prod : '0;
        first    <= p1_valid & p1_first;
        last     <= p1_valid & p1_last;
`ifdef DOT_SEQ_ROWIDX_EN
        p1_row   <= mem_ren ? row : '0;
        row_idx  <= p1_valid ? p1_row : '0;
`endif
      end
    end
  end

endmodule

// File: tb/tb_dot_seq.sv
// Scoreboard bench for dot_seq: directed scenarios plus randomized jobs with random backpressure.
module tb_dot_seq;
  localparam int IW = 8;
  localparam int LW = 6;
  localparam int AW = 10;

  logic clk = 1'b0;
  logic rst, start, ordy;
  logic [LW-1:0] rows, cols;
  logic busy, done, mem_ren, ovalid, first, last;
  logic [LW-1:0] vec_addr;
  logic [AW-1:0] mat_addr;
  logic signed [IW-1:0] vec_rdata, mat_rdata;
  logic signed [2*IW-1:0] data;
`ifdef DOT_SEQ_ROWIDX_EN
  logic [LW-1:0] row_idx;
`endif

  dot_seq #(.IW(IW), .LW(LW), .AW(AW)) dut (
    .clk(clk), .rst(rst), .start(start), .rows(rows), .cols(cols),
    .busy(busy), .done(done), .mem_ren(mem_ren), .vec_addr(vec_addr), .mat_addr(mat_addr),
    .vec_rdata(vec_rdata), .mat_rdata(mat_rdata), .data(data),
    .ovalid(ovalid), .first(first), .last(last), .ordy(ordy)
`ifdef DOT_SEQ_ROWIDX_EN
    , .row_idx(row_idx)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Memories: registered read, data held while mem_ren is low.
  logic signed [IW-1:0] vmem [64];
  logic signed [IW-1:0] mmem [1024];
  always @(posedge clk) if (mem_ren) begin
    vec_rdata <= vmem[vec_addr];
    mat_rdata <= mmem[mat_addr];
  end

  int nvec = 0;
  int nerr = 0;
  task automatic chk(input string name, input bit ok, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (!ok) begin
      nerr++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { logic signed [2*IW-1:0] d; logic f; logic l; } beat_t;
  beat_t sb[$];

  // Reference: beat k of row r is vec[c] * mat[r*cols + c] with exact signed arithmetic.
  task automatic push_job(input int r, input int c);
    beat_t b;
    for (int ri = 0; ri < r; ri++)
      for (int ci = 0; ci < c; ci++) begin
        int p;
        p = int'(vmem[ci]) * int'(mmem[(ri * c + ci) % 1024]);
        b.d = p[2*IW-1:0];
        b.f = (ci == 0);
        b.l = (ci == c - 1);
        sb.push_back(b);
      end
  endtask

  // Backpressure driver
  int  stall_lo = -1, stall_hi = -1;
  bit  rand_ordy = 1'b0;
  initial begin
    ordy = 1'b1;
    forever begin
      @(posedge clk); #1;
      ordy = !(cyc >= stall_lo && cyc <= stall_hi) && (rand_ordy ? ($urandom % 4 != 0) : 1'b1);
    end
  end

  // Monitor
  bit prev_stall = 1'b0;
  logic [2*IW+1:0] prev_beat;
  always @(negedge clk) begin
    logic [2*IW+1:0] cur;
    cur = {data, first, last};
    if (prev_stall)
      chk("stall_hold", ovalid && cur == prev_beat, {14'd0, cur}, {14'd0, prev_beat});
    if (ovalid && ordy) begin
      if (sb.size() == 0) chk("extra_beat", 1'b0, {14'd0, cur}, 32'd0);
      else begin
        beat_t e;
        logic [2*IW+1:0] ev;
        e  = sb.pop_front();
        ev = {e.d, e.f, e.l};
        chk("beat", cur == ev, {14'd0, cur}, {14'd0, ev});
      end
    end
    if (!ovalid) chk("idle_zero", cur == '0, {14'd0, cur}, 32'd0);
    prev_stall = ovalid && !ordy && !rst;
    prev_beat  = cur;
  end

  task automatic fill_rand();
    for (int i = 0; i < 64; i++) vmem[i] = IW'($urandom);
    for (int i = 0; i < 1024; i++) mmem[i] = IW'($urandom);
  endtask

  task automatic load_034();
    vmem[0] = 1; vmem[1] = 2; vmem[2] = 3;
    mmem[0] = 1; mmem[1] = 1; mmem[2] = 1; mmem[3] = -1; mmem[4] = 2; mmem[5] = 4;
  endtask

  // exp_done < 0: done latency not checked (random backpressure)
  task automatic run_job(input int r, input int c, input int exp_done, input bit re_start);
    int t0, n;
    bit got;
    if (r > 0 && c > 0) push_job(r, c);
    @(posedge clk); #1;
    start = 1'b1; rows = LW'(r); cols = LW'(c); t0 = cyc;
    @(posedge clk); #1;
    start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 3000 && !got; k++) begin
      @(negedge clk);
      n = cyc - t0;
      if (re_start) begin
        if (n == 2) begin start = 1'b1; rows = LW'(r + 1); cols = LW'(c); end
        if (n == 3) start = 1'b0;
      end
      if (r == 0 || c == 0)
        chk("zero_quiet", !mem_ren && !ovalid, {30'd0, mem_ren, ovalid}, 32'd0);
      else if (exp_done >= 0) begin
        if (n == 1) chk("first_ren", mem_ren && busy, {30'd0, mem_ren, busy}, 32'd3);
        if (n == 3) chk("first_ovalid", ovalid, {31'd0, ovalid}, 32'd1);
      end
      if (done) begin
        got = 1'b1;
        if (exp_done >= 0) chk("done_time", n == exp_done, n, exp_done);
      end
    end
    if (!got) chk("done_timeout", 1'b0, 32'd0, 32'd1);
    @(negedge clk);
    chk("done_pulse", !done && !busy, {30'd0, done, busy}, 32'd0);
    chk("beats_left", sb.size() == 0, sb.size(), 32'd0);
  endtask

  initial begin
    int r, c, t0;
    rst = 1'b1; start = 1'b0; rows = '0; cols = '0;
    for (int i = 0; i < 64; i++) vmem[i] = '0;
    for (int i = 0; i < 1024; i++) mmem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_state", {busy, done, mem_ren, ovalid, first, last, data, vec_addr, mat_addr} == '0,
        {busy, done, mem_ren, ovalid, 28'd0}, 32'd0);
    rst = 1'b0;

    load_034();
    run_job(2, 3, 8, 1'b0);

    vmem[0] = -128; mmem[0] = -128; mmem[1] = 127; mmem[2] = 0;
    run_job(3, 1, 5, 1'b0);

    load_034();
    @(posedge clk); #1;
    stall_lo = cyc + 5; stall_hi = cyc + 7;   // next job's T is cyc+1
    run_job(2, 3, 11, 1'b0);
    stall_lo = -1; stall_hi = -1;

    run_job(0, 5, 1, 1'b0);
    run_job(4, 0, 1, 1'b0);

    // Abort mid-job with reset
    load_034();
    push_job(2, 3);
    @(posedge clk); #1;
    start = 1'b1; rows = 6'd2; cols = 6'd3; t0 = cyc;
    @(posedge clk); #1; start = 1'b0;
    while (cyc < t0 + 4) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_zero", {busy, done, mem_ren, ovalid, first, last, data, vec_addr, mat_addr} == '0,
        {busy, done, mem_ren, ovalid, 28'd0}, 32'd0);
    sb.delete();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("abort_no_done", !done && !ovalid, {30'd0, done, ovalid}, 32'd0);
    end
    run_job(2, 3, 8, 1'b0);

    // Start re-asserted while busy must be ignored
    fill_rand();
    r = 1 + $urandom % 6; c = 1 + $urandom % 6;
    run_job(r, c, r * c + 2, 1'b1);
    repeat (5) @(negedge clk);

    rand_ordy = 1'b1;
    for (int j = 0; j < 20; j++) begin
      fill_rand();
      r = 1 + $urandom % 8; c = 1 + $urandom % 8;
      run_job(r, c, -1, 1'b0);
    end
    rand_ordy = 1'b0;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout at cycle %0d: got running, expected finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
